// File: rtl/bcd_hex_display.sv
// Sequential double-dabble converter from a 32-bit register value to eight
// active-low seven-segment digits. It re-samples the input after every conversion.
module bcd_hex_display #(
  parameter bit BLANK_LEADING = 1'b1,
  parameter int WIDTH         = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] value_in,
  output logic [6:0]       HEX0,
  output logic [6:0]       HEX1,
  output logic [6:0]       HEX2,
  output logic [6:0]       HEX3,
  output logic [6:0]       HEX4,
  output logic [6:0]       HEX5,
  output logic [6:0]       HEX6,
  output logic [6:0]       HEX7,
  output logic             done,
  output logic             overflow
);

  // state | meaning
  // LOAD  | capture value_in, clear accumulator (also the done cycle)
  // SHIFT | one add-3/shift iteration per input bit, MSB first
  typedef enum logic {LOAD = 1'b0, SHIFT = 1'b1} state_t;

  localparam int NDIG = 10;
  localparam int BCDW = 4 * NDIG;
  localparam int CW   = $clog2(WIDTH + 1);

  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [6:0] SEG_DASH  = 7'b0111111;

  state_t           r_state;
  state_t           w_state_next;
  logic             w_last;
  logic [WIDTH-1:0] r_shreg;
  logic [BCDW-1:0]  r_bcd;
  logic [CW-1:0]    r_cnt;
  logic             r_done;
  logic             r_overflow;
  logic [6:0]       r_hex [8];

  logic [BCDW-1:0]  w_bcd_adj;
  logic [BCDW-1:0]  w_bcd_next;
  logic             w_ovf;
  logic [7:0]       w_zero_hi;
  logic [6:0]       w_hex_next [8];

  function automatic logic [6:0] seg_decode(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = 7'b1000000;
      4'd1:    s = 7'b1111001;
      4'd2:    s = 7'b0100100;
      4'd3:    s = 7'b0110000;
      4'd4:    s = 7'b0011001;
      4'd5:    s = 7'b0010010;
      4'd6:    s = 7'b0000010;
      4'd7:    s = 7'b1111000;
      4'd8:    s = 7'b0000000;
      4'd9:    s = 7'b0010000;
      default: s = SEG_BLANK;
    endcase
    return s;
  endfunction

  always_ff @(posedge clk) begin
    if (rst) r_state <= LOAD;
    else     r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    w_last       = 1'b0;
    case (r_state)
      LOAD:  w_state_next = SHIFT;
      SHIFT: begin
        if (r_cnt == CW'(WIDTH - 1)) begin
          w_last       = 1'b1;
          w_state_next = LOAD;
        end
      end
      default: w_state_next = LOAD;
    endcase
  end

  // Add-3 correction on each digit, then shift the next input bit in.
  always_comb begin
    w_bcd_adj = '0;
    for (int i = 0; i < NDIG; i++) begin
      if (r_bcd[4*i +: 4] >= 4'd5) w_bcd_adj[4*i +: 4] = r_bcd[4*i +: 4] + 4'd3;
      else                         w_bcd_adj[4*i +: 4] = r_bcd[4*i +: 4];
    end
    w_bcd_next = {w_bcd_adj[BCDW-2:0], r_shreg[WIDTH-1]};
  end

  assign w_ovf = |w_bcd_next[BCDW-1:32];

  // w_zero_hi[i] is set when digit i and every digit above it (up to 7) are zero.
  always_comb begin
    w_zero_hi    = '0;
    w_zero_hi[7] = (w_bcd_next[31:28] == 4'd0);
    for (int i = 6; i >= 1; i--) begin
      w_zero_hi[i] = w_zero_hi[i+1] && (w_bcd_next[4*i +: 4] == 4'd0);
    end
  end

  always_comb begin
    for (int i = 0; i < 8; i++) begin
      w_hex_next[i] = seg_decode(w_bcd_next[4*i +: 4]);
      if (w_ovf)                           w_hex_next[i] = SEG_DASH;
      else if (BLANK_LEADING && w_zero_hi[i]) w_hex_next[i] = SEG_BLANK;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_shreg    <= '0;
      r_bcd      <= '0;
      r_cnt      <= '0;
      r_done     <= 1'b0;
      r_overflow <= 1'b0;
      for (int i = 0; i < 8; i++) r_hex[i] <= SEG_BLANK;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        LOAD: begin
          r_shreg <= value_in;
          r_bcd   <= '0;
          r_cnt   <= '0;
        end
        SHIFT: begin
          r_shreg <= r_shreg << 1;
          r_bcd   <= w_bcd_next;
          r_cnt   <= r_cnt + CW'(1);
          if (w_last) begin
            for (int i = 0; i < 8; i++) r_hex[i] <= w_hex_next[i];
            r_overflow <= w_ovf;
            r_done     <= 1'b1;
          end
        end
        default: r_cnt <= '0;
      endcase
    end
  end

  assign HEX0     = r_hex[0];
  assign HEX1     = r_hex[1];
  assign HEX2     = r_hex[2];
  assign HEX3     = r_hex[3];
  assign HEX4     = r_hex[4];
  assign HEX5     = r_hex[5];
  assign HEX6     = r_hex[6];
  assign HEX7     = r_hex[7];
  assign done     = r_done;
  assign overflow = r_overflow;

endmodule

// File: tb/tb_bcd_hex_display.sv
// Directed bench for bcd_hex_display, with blanking on (u0) and off (u1).
module tb_bcd_hex_display;

  localparam logic [6:0] S0 = 7'b1000000, S1 = 7'b1111001, S2 = 7'b0100100,
                         S3 = 7'b0110000, S4 = 7'b0011001, S5 = 7'b0010010,
                         S6 = 7'b0000010, S7 = 7'b1111000, S8 = 7'b0000000,
                         S9 = 7'b0010000, BL = 7'h7F,      DS = 7'b0111111;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] value_in;
  logic [6:0]  a0, a1, a2, a3, a4, a5, a6, a7;
  logic [6:0]  b0, b1, b2, b3, b4, b5, b6, b7;
  logic        done0, done1, ovf0, ovf1;
  int          checks = 0;
  int          errors = 0;
  int          n;

  always #5 clk = ~clk;

  bcd_hex_display #(.BLANK_LEADING(1'b1), .WIDTH(32)) u0 (
    .clk(clk), .rst(rst), .value_in(value_in),
    .HEX0(a0), .HEX1(a1), .HEX2(a2), .HEX3(a3),
    .HEX4(a4), .HEX5(a5), .HEX6(a6), .HEX7(a7),
    .done(done0), .overflow(ovf0)
  );

  bcd_hex_display #(.BLANK_LEADING(1'b0), .WIDTH(32)) u1 (
    .clk(clk), .rst(rst), .value_in(value_in),
    .HEX0(b0), .HEX1(b1), .HEX2(b2), .HEX3(b3),
    .HEX4(b4), .HEX5(b5), .HEX6(b6), .HEX7(b7),
    .done(done1), .overflow(ovf1)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Wait for the next done pulse on u0, bounded at 40 cycles.
  task automatic wait_done(output int cyc);
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
    end while (!done0 && cyc < 40);
  endtask

  task automatic chk_disp(input string tag, input logic [55:0] exp0,
                          input logic [55:0] exp1, input logic exp_ovf);
    chk({tag, "_u0"}, {8'h0, a7, a6, a5, a4, a3, a2, a1, a0}, {8'h0, exp0});
    chk({tag, "_u1"}, {8'h0, b7, b6, b5, b4, b3, b2, b1, b0}, {8'h0, exp1});
    chk({tag, "_ovf0"}, {63'h0, ovf0}, {63'h0, exp_ovf});
    chk({tag, "_ovf1"}, {63'h0, ovf1}, {63'h0, exp_ovf});
    chk({tag, "_done1"}, {63'h0, done1}, {63'h0, done0});
  endtask

  initial begin
    rst      = 1'b1;
    value_in = 32'd0;
    repeat (3) @(negedge clk);
    chk_disp("reset", {8{BL}}, {8{BL}}, 1'b0);
    chk("reset_done", {63'h0, done0}, 64'h0);

    rst = 1'b0;
    wait_done(n);
    chk("lat_zero", n, 33);
    chk_disp("zero", {{7{BL}}, S0}, {8{S0}}, 1'b0);

    value_in = 32'd2;
    wait_done(n);
    chk("lat_two", n, 33);
    chk_disp("two", {{7{BL}}, S2}, {{7{S0}}, S2}, 1'b0);

    value_in = 32'd12345678;
    wait_done(n);
    chk("lat_12345678", n, 33);
    chk_disp("v12345678", {S1, S2, S3, S4, S5, S6, S7, S8},
             {S1, S2, S3, S4, S5, S6, S7, S8}, 1'b0);
    @(negedge clk);
    chk("done_one_cycle", {63'h0, done0}, 64'h0);
    wait_done(n);
    chk("period_12345678", n, 32);
    chk_disp("v12345678_hold", {S1, S2, S3, S4, S5, S6, S7, S8},
             {S1, S2, S3, S4, S5, S6, S7, S8}, 1'b0);

    value_in = 32'd99999999;
    wait_done(n);
    chk("lat_99999999", n, 33);
    chk_disp("v99999999", {8{S9}}, {8{S9}}, 1'b0);

    value_in = 32'd1000203;
    wait_done(n);
    chk_disp("v1000203", {BL, S1, S0, S0, S0, S2, S0, S3},
             {S0, S1, S0, S0, S0, S2, S0, S3}, 1'b0);

    value_in = 32'd100000000;
    wait_done(n);
    chk_disp("v100000000", {8{DS}}, {8{DS}}, 1'b1);

    value_in = 32'hFFFFFFFF;
    wait_done(n);
    chk_disp("vFFFFFFFF", {8{DS}}, {8{DS}}, 1'b1);

    value_in = 32'd5;
    repeat (10) @(negedge clk);
    value_in = 32'd7;
    wait_done(n);
    chk("lat_midchange", n, 23);
    chk_disp("midchange_5", {{7{BL}}, S5}, {{7{S0}}, S5}, 1'b0);
    wait_done(n);
    chk("lat_after_change", n, 33);
    chk_disp("midchange_7", {{7{BL}}, S7}, {{7{S0}}, S7}, 1'b0);

    value_in = 32'd9;
    repeat (21) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk_disp("midreset", {8{BL}}, {8{BL}}, 1'b0);
    chk("midreset_done", {63'h0, done0}, 64'h0);
    repeat (3) @(negedge clk);
    chk("rst_held_done", {63'h0, done0}, 64'h0);
    rst = 1'b0;
    wait_done(n);
    chk("lat_post_reset", n, 33);
    chk_disp("post_reset_9", {{7{BL}}, S9}, {{7{S0}}, S9}, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
